// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for the async FIFO.
// Issues pops against the registered-read RAM, tracks words still in flight
// through the RAM read latency, and lands them in a small skid buffer. That
// buffer feeds a valid/ready stream with per-frame last marking and flush.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 4,
    parameter int RD_LAT     = 1,
    parameter int FRAME_LEN  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           frame_cnt
);

    // One buffer slot per cycle of read latency, plus one for the word being consumed.
    localparam int SKID_DEPTH = RD_LAT + 1;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
    localparam int LVL_W      = OCC_W + 1;
    localparam int PTR_W      = $clog2(SKID_DEPTH);
    localparam int BEAT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(SKID_DEPTH - 1);

    logic [RD_LAT-1:0]     pipe_r;
    logic [DATA_WIDTH-1:0] buf_r [SKID_DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [OCC_W-1:0]      occ_r;
    logic [BEAT_W-1:0]     beat_cnt_r;
    logic [15:0]           frame_cnt_r;

    logic [OCC_W-1:0]      inflight_s;
    logic [LVL_W-1:0]      level_s;
    logic [LVL_W-1:0]      limit_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  wr_s;
    logic                  rd_en_s;
    logic                  last_s;

    // Number of reads issued to the RAM whose data has not yet landed.
    function automatic logic [OCC_W-1:0] count_ones(input logic [RD_LAT-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : (p + PTR_W'(1));
    endfunction

    // Handshake, pop-request and frame-marker decode from the current state.
    always_comb begin
        inflight_s = count_ones(pipe_r);
        valid_s    = (occ_r != '0) && !flush && !rd_rst;
        pop_s      = valid_s && m_ready;
        wr_s       = pipe_r[RD_LAT-1];
        level_s    = LVL_W'(occ_r) + LVL_W'(inflight_s);
        limit_s    = LVL_W'(SKID_DEPTH) + LVL_W'(pop_s);
        // A slot freed by this cycle's pop may be reserved by this cycle's request.
        if (!rd_rst && !flush && !fifo_empty && (level_s < limit_s)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
        last_s     = valid_s && (beat_cnt_r == BEAT_LAST);
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = valid_s;
    assign m_last     = last_s;
    assign m_data     = buf_r[head_r];
    assign frame_cnt  = frame_cnt_r;

    // Latency pipe, skid buffer, occupancy and frame counters; reset beats flush.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            pipe_r      <= '0;
            head_r      <= '0;
            tail_r      <= '0;
            occ_r       <= '0;
            beat_cnt_r  <= '0;
            frame_cnt_r <= 16'd0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                buf_r[i] <= '0;
            end
        end else if (flush) begin
            // Clearing the pipe discards any word still returning from the RAM.
            pipe_r     <= '0;
            head_r     <= '0;
            tail_r     <= '0;
            occ_r      <= '0;
            beat_cnt_r <= '0;
        end else begin
            pipe_r[0] <= rd_en_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
            if (wr_s) begin
                buf_r[tail_r] <= fifo_rd_data;
                tail_r        <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
                if (last_s) begin
                    beat_cnt_r  <= '0;
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                end else begin
                    beat_cnt_r  <= beat_cnt_r + BEAT_W'(1);
                end
            end
            case ({wr_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two lanes (RD_LAT=1/FRAME_LEN=4 and
// RD_LAT=2/FRAME_LEN=1) driven from a FIFO+RAM environment and compared every
// cycle against a queue-based reference model.
module tb_fifo_rd_stream;

    localparam int NL = 2;

    logic           rd_clk;
    logic           rd_rst;
    logic           flush;
    logic [NL-1:0]  fifo_empty;
    logic [NL-1:0]  fifo_rd_en;
    logic [NL-1:0]  m_valid;
    logic [NL-1:0]  m_ready;
    logic [NL-1:0]  m_last;
    logic [3:0]     fifo_rd_data [NL];
    logic [3:0]     m_data [NL];
    logic [15:0]    frame_cnt [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        fifo_rd_stream #(
            .DATA_WIDTH (4),
            .RD_LAT     (g + 1),
            .FRAME_LEN  ((g == 0) ? 4 : 1)
        ) dut (
            .rd_clk       (rd_clk),
            .rd_rst       (rd_rst),
            .fifo_empty   (fifo_empty[g]),
            .fifo_rd_en   (fifo_rd_en[g]),
            .fifo_rd_data (fifo_rd_data[g]),
            .flush        (flush),
            .m_valid      (m_valid[g]),
            .m_ready      (m_ready[g]),
            .m_data       (m_data[g]),
            .m_last       (m_last[g]),
            .frame_cnt    (frame_cnt[g])
        );
    end

    // Free-running read clock.
    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Environment: FIFO contents and words travelling through the RAM.
    logic [3:0] src_q   [NL][$];
    logic [3:0] fl_w    [NL][$];
    int         fl_rem  [NL][$];
    bit         fl_live [NL][$];
    // Reference model: buffered words and frame position.
    logic [3:0] exp_buf [NL][$];
    int         beats  [NL];
    int         frames [NL];

    int n_cmp;
    int n_bad;
    int hold_pct;
    bit s_en   [NL];
    bit s_vld  [NL];
    bit s_last [NL];
    logic [3:0]  s_data  [NL];
    logic [15:0] s_frame [NL];

    function automatic int lat_of(int g);
        return g + 1;
    endfunction

    function automatic int flen_of(int g);
        return (g == 0) ? 4 : 1;
    endfunction

    task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d: got %0h want %0h", nm, g, act, exp);
        end
    endtask

    // One clock cycle: drive environment, check at negedge, advance model after posedge.
    task automatic step();
        bit pop_now [NL];
        bit en_now  [NL];
        bit rst_now;
        bit flush_now;
        for (int g = 0; g < NL; g++) begin
            if (src_q[g].size() == 0) fifo_empty[g] = 1'b1;
            else fifo_empty[g] = ($urandom_range(99) < hold_pct);
            if (fl_rem[g].size() != 0 && fl_rem[g][0] == 1) fifo_rd_data[g] = fl_w[g][0];
            else fifo_rd_data[g] = 4'($urandom);
        end
        @(negedge rd_clk);
        for (int g = 0; g < NL; g++) begin
            int  live_n;
            bit  e_vld, e_pop, e_en, e_last;
            live_n = 0;
            foreach (fl_live[g][i]) if (fl_live[g][i]) live_n++;
            e_vld  = !rd_rst && !flush && (exp_buf[g].size() != 0);
            e_pop  = e_vld && m_ready[g];
            e_en   = !rd_rst && !flush && !fifo_empty[g] &&
                     (exp_buf[g].size() + live_n - (e_pop ? 1 : 0) < lat_of(g) + 1);
            e_last = e_vld && (beats[g] == flen_of(g) - 1);
            chk("fifo_rd_en", g, 32'(fifo_rd_en[g]), 32'(e_en));
            chk("m_valid",    g, 32'(m_valid[g]),    32'(e_vld));
            chk("m_last",     g, 32'(m_last[g]),     32'(e_last));
            chk("frame_cnt",  g, 32'(frame_cnt[g]),  32'(frames[g]));
            if (e_vld) chk("m_data", g, 32'(m_data[g]), 32'(exp_buf[g][0]));
            s_en[g]    = fifo_rd_en[g];
            s_vld[g]   = m_valid[g];
            s_last[g]  = m_last[g];
            s_data[g]  = m_data[g];
            s_frame[g] = frame_cnt[g];
            pop_now[g] = e_pop;
            en_now[g]  = fifo_rd_en[g];
        end
        rst_now   = rd_rst;
        flush_now = flush;
        @(posedge rd_clk);
        #1;
        for (int g = 0; g < NL; g++) begin
            if (pop_now[g]) begin
                void'(exp_buf[g].pop_front());
                if (beats[g] == flen_of(g) - 1) begin
                    beats[g]  = 0;
                    frames[g] = (frames[g] + 1) % 65536;
                end else begin
                    beats[g]++;
                end
            end
            if (fl_rem[g].size() != 0 && fl_rem[g][0] == 1) begin
                logic [3:0] w;
                bit lv;
                w  = fl_w[g].pop_front();
                lv = fl_live[g].pop_front();
                void'(fl_rem[g].pop_front());
                if (lv && !rst_now && !flush_now) begin
                    chk("no_overflow", g, 32'(exp_buf[g].size() < lat_of(g) + 1), 32'd1);
                    exp_buf[g].push_back(w);
                end
            end
            foreach (fl_rem[g][i]) fl_rem[g][i] = fl_rem[g][i] - 1;
            if (en_now[g] && src_q[g].size() != 0) begin
                fl_w[g].push_back(src_q[g].pop_front());
                fl_rem[g].push_back(lat_of(g));
                fl_live[g].push_back(!rst_now && !flush_now);
            end
            if (rst_now || flush_now) begin
                exp_buf[g].delete();
                beats[g] = 0;
                foreach (fl_live[g][i]) fl_live[g][i] = 1'b0;
            end
            if (rst_now) begin
                frames[g] = 0;
                src_q[g].delete();
            end
        end
    endtask

    // Directed pins, randomized soak, then reset-with-flush recovery.
    initial begin
        bit [9:0]   en_bits  [NL];
        bit [9:0]   vld_bits [NL];
        bit [9:0]   last_bits[NL];
        logic [3:0] got [NL][$];
        int         mode;
        n_cmp = 0;
        n_bad = 0;
        hold_pct = 0;
        rd_rst = 1'b1;
        flush  = 1'b0;
        for (int g = 0; g < NL; g++) begin
            m_ready[g] = 1'b1;
            fifo_empty[g] = 1'b1;
            fifo_rd_data[g] = 4'd0;
            beats[g] = 0;
            frames[g] = 0;
        end
        repeat (2) @(posedge rd_clk);
        #1;
        step();
        rd_rst = 1'b0;
        step();

        // Five words 1..5, sink always ready, no empty holes.
        for (int g = 0; g < NL; g++) begin
            for (int k = 1; k <= 5; k++) src_q[g].push_back(4'(k));
            en_bits[g] = '0;
            vld_bits[g] = '0;
            last_bits[g] = '0;
        end
        for (int c = 0; c < 10; c++) begin
            step();
            for (int g = 0; g < NL; g++) begin
                en_bits[g][c]   = s_en[g];
                vld_bits[g][c]  = s_vld[g];
                last_bits[g][c] = s_last[g];
                if (s_vld[g]) got[g].push_back(s_data[g]);
            end
        end
        chk("p1_rd_en_cycles",  0, 32'(en_bits[0]),   32'h01F);
        chk("p1_valid_cycles",  0, 32'(vld_bits[0]),  32'h07C);
        chk("p1_last_cycles",   0, 32'(last_bits[0]), 32'h020);
        chk("p1_frames",        0, 32'(s_frame[0]),   32'd1);
        chk("p1_rd_en_cycles",  1, 32'(en_bits[1]),   32'h01F);
        chk("p1_valid_cycles",  1, 32'(vld_bits[1]),  32'h0F8);
        chk("p1_last_cycles",   1, 32'(last_bits[1]), 32'h0F8);
        chk("p1_frames",        1, 32'(s_frame[1]),   32'd5);
        for (int g = 0; g < NL; g++) begin
            chk("p1_beat_count", g, 32'(got[g].size()), 32'd5);
            for (int k = 0; k < got[g].size(); k++) chk("p1_order", g, 32'(got[g][k]), 32'(k + 1));
        end

        // Randomized soak: varying backpressure, empty holes, flushes, resets.
        for (int c = 0; c < 4000; c++) begin
            mode = (c / 500) % 4;
            hold_pct = (mode == 3) ? 40 : 10;
            rd_rst = ($urandom_range(399) == 0);
            flush  = rd_rst ? 1'($urandom_range(1)) : ($urandom_range(49) == 0);
            for (int g = 0; g < NL; g++) begin
                case (mode)
                    0:       m_ready[g] = 1'b1;
                    1:       m_ready[g] = (c % 3 == 0);
                    2:       m_ready[g] = 1'($urandom_range(1));
                    default: m_ready[g] = ($urandom_range(3) != 0);
                endcase
                if (src_q[g].size() < 12 && $urandom_range(99) < 70) src_q[g].push_back(4'($urandom));
            end
            step();
        end

        // Reset with flush mid-stream: no residue until the FIFO refills.
        hold_pct = 0;
        rd_rst = 1'b0;
        flush  = 1'b0;
        for (int g = 0; g < NL; g++) begin
            m_ready[g] = 1'b0;
            repeat (6) src_q[g].push_back(4'($urandom));
        end
        repeat (4) step();
        rd_rst = 1'b1;
        flush  = 1'b1;
        step();
        rd_rst = 1'b0;
        flush  = 1'b0;
        for (int g = 0; g < NL; g++) m_ready[g] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            for (int g = 0; g < NL; g++) begin
                chk("p6_no_residue_valid", g, 32'(s_vld[g]), 32'd0);
                chk("p6_frame_cleared",    g, 32'(s_frame[g]), 32'd0);
            end
        end
        for (int g = 0; g < NL; g++) src_q[g].push_back(4'hA);
        repeat (6) step();
        chk("p6_refill_frames", 0, 32'(s_frame[0]), 32'd0);
        chk("p6_refill_frames", 1, 32'(s_frame[1]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side drain engine for the async FIFO. It runs in the read clock domain and issues FIFO pops against the registered-read dual-port RAM, compensating for its read latency. Popped words are presented on a valid/ready stream with full 1-word/cycle throughput, per-frame m_last marking and a synchronous flush. It sits between the FIFO read port and any downstream consumer.

Parameters:
DATA_WIDTH, 4, width of FIFO words and m_data
RD_LAT, 1, cycles from fifo_rd_en high to word valid on fifo_rd_data; legal values 1 or 2
FRAME_LEN, 16, beats per frame; must be >= 1; m_last marks beat FRAME_LEN-1
SKID_DEPTH, RD_LAT+1, internal buffer entries (localparam, not overridable)

Ports:
rd_clk  input  1  read-domain clock; all logic on its rising edge
rd_rst  input  1  synchronous, active-high reset
fifo_empty  input  1  FIFO empty flag (read domain)
fifo_rd_en  output  1  FIFO pop request
fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid RD_LAT cycles after fifo_rd_en
flush  input  1  synchronous drop of all buffered and in-flight words
m_valid  output  1  stream word available
m_ready  input  1  downstream accepts word
m_data  output  DATA_WIDTH  stream word
m_last  output  1  final beat of current frame
frame_cnt  output  16  completed frames, wraps at 65535 -> 0

Behaviour:
- Reset (rd_rst high at an edge):
  - Buffer occupancy (occ), in-flight pipe, beat_cnt and frame_cnt all go to 0.
  - m_data registers go to 0.
  - While rd_rst is high, fifo_rd_en, m_valid and m_last are forced to 0.
- In-flight pipe: RD_LAT-deep shift register of valid bits.
  - Stage 0 loads fifo_rd_en.
  - When the last stage is 1, fifo_rd_data is written to the buffer tail.
  - inflight = count of set bits in the pipe.
- Buffer: SKID_DEPTH-entry circular FIFO with head and tail pointers.
  - m_data = head entry.
  - m_valid = (occ != 0) && !flush.
- Handshake: pop = m_valid && m_ready.
  - On pop, the head advances and beat_cnt advances.
  - m_data is held stable while m_valid && !m_ready.
- Pop request (combinational): fifo_rd_en = !rd_rst && !flush && !fifo_empty && (occ + inflight - pop < SKID_DEPTH).
  - Never asserted while fifo_empty = 1.
- Simultaneous buffer write and pop in one cycle: occ is unchanged and both pointers advance.
- Throughput and latency:
  - With m_ready held 1 and the FIFO non-empty, one beat per cycle is sustained.
  - First-word latency: fifo_rd_en at cycle N gives data on fifo_rd_data at N+RD_LAT and m_valid at N+RD_LAT+1.
- Frames:
  - m_last = m_valid && (beat_cnt == FRAME_LEN-1).
  - On pop with m_last, beat_cnt goes to 0 and frame_cnt increments.
  - On any other pop, beat_cnt increments.
  - FRAME_LEN = 1: every beat carries m_last.
- Flush (sampled at the edge):
  - occ, pointers, pipe valid bits and beat_cnt go to 0. Words returning from RAM after the flush edge are discarded.
  - During the flush cycle, m_valid = 0 (no handshake) and fifo_rd_en = 0.
  - frame_cnt is not cleared.
- rd_rst has priority over flush.
- Backpressure: with m_ready = 0, requests stop once occ + inflight = SKID_DEPTH. No buffer overwrite ever occurs.
- fifo_empty may deassert and reassert at any time. The block only reacts to fifo_empty in the cycle it would request.
- No width growth: occ and pointers are sized for SKID_DEPTH. Counters wrap modulo their width.

Test Plan:
1. Reset, then preload 5 words 0x1..0x5 into the FIFO model, RD_LAT=1, m_ready=1 -> fifo_rd_en high at cycles 0..4; m_valid at cycles 2..6 with data 1,2,3,4,5; no bubbles.
2. FIFO holding 8 words, m_ready toggling 1,0,0,1,... -> occ never exceeds 2; m_data stable while stalled; output order exact; fifo_rd_en never high with fifo_empty=1.
3. FRAME_LEN=4, 10 beats accepted -> m_last on beats 3 and 7; frame_cnt=2; beat_cnt=2 at end.
4. Flush with occ=2, one read in flight, mid-frame at beat 2 -> m_valid 0 during flush; in-flight word dropped; next accepted word is the following FIFO entry with beat_cnt=0; frame_cnt unchanged.
5. RD_LAT=2, continuous stream of 20 words, m_ready=1 -> first m_valid 3 cycles after first fifo_rd_en; then 1 beat/cycle; SKID_DEPTH=3 never exceeded.
6. Assert rd_rst mid-stream with flush also high -> all outputs 0 the next cycle; frame_cnt=0; no residual words appear after reset release until the FIFO is refilled.
